axis_packet_fifo: RTL and testbench

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/axis_xbar_pkg.sv | 13 +
 rtl/axis_pkt_fifo_mem.sv | 27 ++
 rtl/axis_packet_fifo.sv | 168 ++++++++++++++++
 tb/tb_axis_packet_fifo.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_xbar_pkg.sv
// Shared AXI-Stream crossbar definitions: default data width, beat record and
// drop counter width used by the packet FIFO.
package axis_xbar_pkg;

   localparam int AXIS_DATA_WIDTH = 32;
   localparam int DROP_CNT_WIDTH  = 16;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] tdata;
      logic                       tlast;
   } axis_beat_t;

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// Simple dual-port beat storage for the packet FIFO: synchronous write port,
// asynchronous read port so the FIFO head is visible in the same cycle.
module axis_pkt_fifo_mem
   import axis_xbar_pkg::*;
#(
   parameter int  ADDR_WIDTH = 6,
   parameter type beat_t     = axis_beat_t
) (
   input  logic                  aclk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  beat_t                 wr_beat_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output beat_t                 rd_beat_o
);

   beat_t mem_q [2**ADDR_WIDTH];

   always_ff @(posedge aclk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_beat_i;
      end
   end

   assign rd_beat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO feeding one crossbar slave channel.
// AXIS_PKT_FIFO_DROP_EN selects drop-on-overflow instead of backpressure plus cut-through.
module axis_packet_fifo
   import axis_xbar_pkg::*;
#(
   parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [DEPTH_LOG2:0]   fill_level,
   output logic [DEPTH_LOG2:0]   pkt_count
`ifdef AXIS_PKT_FIFO_DROP_EN
   ,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
      logic                  tlast;
   } fifo_beat_t;

   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] PTR_ONE    = 1;

   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] wr_start_q, wr_start_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0] pkt_cnt_q, pkt_cnt_d;
   logic                cut_through_q, cut_through_d;
   logic                dropping_q, dropping_d;

   logic [DEPTH_LOG2:0] level;
   logic                full, empty;
   logic                accept, pop, pop_last, wr_en, commit;
   fifo_beat_t          wr_beat, rd_beat;

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == FULL_LEVEL);
   assign empty = (level == '0);

`ifdef AXIS_PKT_FIFO_DROP_EN
   assign s_axis_tready = !areset;
`else
   assign s_axis_tready = !areset && !full;
`endif

   assign m_axis_tvalid = !areset && !empty && ((pkt_cnt_q != '0) || cut_through_q);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign pop_last      = pop && rd_beat.tlast;
   // Beats arriving while full or while discarding a packet never touch memory.
   assign wr_en         = accept && !full && !dropping_q;
   assign commit        = wr_en && s_axis_tlast;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      wr_start_d    = wr_start_q;
      rd_ptr_d      = rd_ptr_q;
      pkt_cnt_d     = pkt_cnt_q;
      cut_through_d = cut_through_q;
      dropping_d    = dropping_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (commit) begin
         wr_start_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (commit && !pop_last) begin
         pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      end else if (!commit && pop_last) begin
         pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      end

`ifdef AXIS_PKT_FIFO_DROP_EN
      cut_through_d = 1'b0;
      if (accept && dropping_q) begin
         dropping_d = !s_axis_tlast;
      end else if (accept && full) begin
         wr_ptr_d   = wr_start_q;
         dropping_d = !s_axis_tlast;
      end
`else
      dropping_d = 1'b0;
      // A full FIFO with no complete packet can only drain by streaming.
      if (pop_last) begin
         cut_through_d = 1'b0;
      end else if (full && (pkt_cnt_q == '0)) begin
         cut_through_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q      <= '0;
         wr_start_q    <= '0;
         rd_ptr_q      <= '0;
         pkt_cnt_q     <= '0;
         cut_through_q <= 1'b0;
         dropping_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         wr_start_q    <= wr_start_d;
         rd_ptr_q      <= rd_ptr_d;
         pkt_cnt_q     <= pkt_cnt_d;
         cut_through_q <= cut_through_d;
         dropping_q    <= dropping_d;
      end
   end

`ifdef AXIS_PKT_FIFO_DROP_EN
   localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = 1;

   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && full && !dropping_q && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_ONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`endif

   assign wr_beat.tdata = s_axis_tdata;
   assign wr_beat.tlast = s_axis_tlast;

   axis_pkt_fifo_mem #(
      .ADDR_WIDTH (DEPTH_LOG2),
      .beat_t     (fifo_beat_t)
   ) u_mem (
      .aclk      (aclk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
      .wr_beat_i (wr_beat),
      .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
      .rd_beat_o (rd_beat)
   );

   assign m_axis_tdata = rd_beat.tdata;
   assign m_axis_tlast = rd_beat.tlast;
   assign fill_level   = areset ? '0 : level;
   assign pkt_count    = areset ? '0 : pkt_cnt_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Self-checking bench for axis_packet_fifo (DEPTH_LOG2=3) against a queue-based
// model of the packet FIFO rules; covers both default and drop builds.
module tb_axis_packet_fifo;

   localparam int DW    = 32;
   localparam int DL    = 3;
   localparam int DEPTH = 8;

   logic          aclk = 1'b0;
   logic          areset;
   logic [DW-1:0] s_tdata, m_tdata;
   logic          s_tvalid, s_tlast, s_tready;
   logic          m_tvalid, m_tlast, m_tready;
   logic [DL:0]   fill_level, pkt_count;
`ifdef AXIS_PKT_FIFO_DROP_EN
   logic [15:0]   drop_count;
`endif

   always #5 aclk = ~aclk;

   axis_packet_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH_LOG2 (DL)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .fill_level    (fill_level),
      .pkt_count     (pkt_count)
`ifdef AXIS_PKT_FIFO_DROP_EN
      ,
      .drop_count    (drop_count)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } mbeat_t;

   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic        sl;
      logic        mr;
      logic        e_tready;
      logic        e_tvalid;
      int          e_fill;
      int          e_pkt;
      logic [31:0] e_data;
      logic        e_last;
   } vec_t;

   // Reference model: stored beats in arrival order, committed packets are
   // the tlast beats present in the queue.
   mbeat_t mq[$];
   mbeat_t rxq[$];
   bit     m_ct;
   bit     m_drop;
   int     m_part;
   int     m_dropcnt;

   logic        o_tready, o_tvalid, o_tlast;
   logic [31:0] o_tdata;
   logic [DL:0] o_fill, o_pkt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int n_last();
      int n = 0;
      foreach (mq[i]) if (mq[i].l) n++;
      return n;
   endfunction

   task automatic cycle(input logic rst, input logic sv, input logic [31:0] sd,
                        input logic sl, input logic mr);
      logic   e_tready, e_tvalid;
      int     e_fill, e_pkt, nl;
      bit     acc, pop, was_full;
      mbeat_t b;
      @(negedge aclk);
      areset   = rst;
      s_tvalid = sv;
      s_tdata  = sd;
      s_tlast  = sl;
      m_tready = mr;
      #1;
      o_tready = s_tready;
      o_tvalid = m_tvalid;
      o_tdata  = m_tdata;
      o_tlast  = m_tlast;
      o_fill   = fill_level;
      o_pkt    = pkt_count;

      nl     = n_last();
      e_fill = rst ? 0 : mq.size();
      e_pkt  = rst ? 0 : nl;
`ifdef AXIS_PKT_FIFO_DROP_EN
      e_tready = !rst;
`else
      e_tready = !rst && (mq.size() < DEPTH);
`endif
      e_tvalid = !rst && (mq.size() > 0) && (nl > 0 || m_ct);
      chk("tready", o_tready, e_tready);
      chk("tvalid", o_tvalid, e_tvalid);
      chk("fill_level", o_fill, e_fill);
      chk("pkt_count", o_pkt, e_pkt);
      if (e_tvalid && o_tvalid) begin
         chk("tdata", o_tdata, mq[0].d);
         chk("tlast", o_tlast, mq[0].l);
      end
`ifdef AXIS_PKT_FIFO_DROP_EN
      if (!rst) chk("drop_count", drop_count, m_dropcnt);
`endif
      if (o_tvalid && mr) rxq.push_back('{d: o_tdata, l: o_tlast});

      if (rst) begin
         mq.delete();
         m_ct      = 0;
         m_drop    = 0;
         m_part    = 0;
         m_dropcnt = 0;
      end else begin
         was_full = (mq.size() == DEPTH);
         pop      = e_tvalid && mr;
         acc      = sv && e_tready;
         if (pop) begin
            b = mq.pop_front();
            if (b.l) m_ct = 0;
         end
`ifdef AXIS_PKT_FIFO_DROP_EN
         if (acc) begin
            if (m_drop) begin
               m_drop = !sl;
            end else if (was_full) begin
               repeat (m_part) void'(mq.pop_back());
               m_part = 0;
               if (m_dropcnt < 65535) m_dropcnt++;
               m_drop = !sl;
            end else begin
               mq.push_back('{d: sd, l: sl});
               m_part = sl ? 0 : m_part + 1;
            end
         end
`else
         if (acc) mq.push_back('{d: sd, l: sl});
         if (was_full && nl == 0) m_ct = 1;
`endif
      end
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (mq.size() > 0 && n < max_cycles) begin
         cycle(0, 0, 0, 0, 1);
         n++;
      end
      cycle(0, 0, 0, 0, 1);
      chk("drain_fill", o_fill, 0);
   endtask

   vec_t   tbl[7];
   mbeat_t tx[$];

   initial begin
      int     idx, cyc, len, pos;
      logic   sv, mr, sl;
      logic [31:0] sd;

      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;

      //            sv  sd     sl  mr  rdy vld fill pkt data   last
      tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0,  1'b0};
      tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 32'h11, 1'b1};
      tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 2, 2, 32'h11, 1'b1};
      tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 3, 3, 32'h11, 1'b1};
      tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 2, 2, 32'h22, 1'b1};
      tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 32'h33, 1'b1};
      tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0,  1'b0};

      cycle(1, 0, 0, 0, 0);
      cycle(1, 1, 32'h5, 0, 1);
      chk("rst_tready", o_tready, 0);
      chk("rst_tvalid", o_tvalid, 0);

      // Back-to-back single-beat packets held, then released.
      for (int k = 0; k < 7; k++) begin
         cycle(0, tbl[k].sv, tbl[k].sd, tbl[k].sl, tbl[k].mr);
         chk("tbl_tready", o_tready, tbl[k].e_tready);
         chk("tbl_tvalid", o_tvalid, tbl[k].e_tvalid);
         chk("tbl_fill", o_fill, tbl[k].e_fill);
         chk("tbl_pkt", o_pkt, tbl[k].e_pkt);
         if (tbl[k].e_tvalid) begin
            chk("tbl_tdata", o_tdata, tbl[k].e_data);
            chk("tbl_tlast", o_tlast, tbl[k].e_last);
         end
      end

      // Single 4-beat packet latency.
      rxq.delete();
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 32'hA0 + i, i == 3, 1);
         chk("lat_tvalid_pre", o_tvalid, 0);
      end
      cycle(0, 0, 0, 0, 1);
      chk("lat_tvalid", o_tvalid, 1);
      chk("lat_tdata", o_tdata, 32'hA0);
      chk("lat_pkt", o_pkt, 1);
      drain(20);
      chk("lat_rx_size", rxq.size(), 4);
      for (int i = 0; i < 4 && i < rxq.size(); i++) begin
         chk("lat_rx_data", rxq[i].d, 32'hA0 + i);
         chk("lat_rx_last", rxq[i].l, i == 3);
      end

`ifdef AXIS_PKT_FIFO_DROP_EN
      // Stored 5-beat packet, then a 6-beat packet that overflows.
      rxq.delete();
      for (int i = 0; i < 5; i++) cycle(0, 1, 32'hD0 + i, i == 4, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 32'hE0 + i, i == 5, 0);
      cycle(0, 0, 0, 0, 0);
      chk("drop_cnt", drop_count, 1);
      chk("drop_fill", o_fill, 5);
      chk("drop_pkt", o_pkt, 1);
      drain(30);
      chk("drop_rx_size", rxq.size(), 5);
      for (int i = 0; i < 5 && i < rxq.size(); i++) begin
         chk("drop_rx_data", rxq[i].d, 32'hD0 + i);
         chk("drop_rx_last", rxq[i].l, i == 4);
      end
`else
      // Oversize 12-beat packet forces cut-through.
      rxq.delete();
      idx = 0;
      cyc = 0;
      while (cyc < 20) begin
         cycle(0, 1, 32'hC0 + idx, idx == 11, 0);
         cyc++;
         if (o_tready) idx++;
         if (o_fill == 4'd8) break;
      end
      chk("ovs_full_tready", o_tready, 0);
      chk("ovs_accepted", idx, 8);
      cycle(0, 1, 32'hC0 + idx, 0, 0);
      chk("ovs_ct_tvalid", o_tvalid, 1);
      chk("ovs_ct_data", o_tdata, 32'hC0);
      cyc = 0;
      while (idx < 12 && cyc < 60) begin
         cycle(0, 1, 32'hC0 + idx, idx == 11, 1);
         cyc++;
         if (o_tready) idx++;
      end
      chk("ovs_send_done", idx, 12);
      drain(30);
      chk("ovs_rx_size", rxq.size(), 12);
      for (int i = 0; i < 12 && i < rxq.size(); i++) begin
         chk("ovs_rx_data", rxq[i].d, 32'hC0 + i);
         chk("ovs_rx_last", rxq[i].l, i == 11);
      end
`endif

      // Reset in the middle of a packet.
      rxq.delete();
      cycle(0, 1, 32'hF0, 0, 0);
      cycle(0, 1, 32'hF1, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("mrst_fill", o_fill, 0);
      chk("mrst_tvalid", o_tvalid, 0);
      cycle(0, 1, 32'hB0, 0, 0);
      cycle(0, 1, 32'hB1, 1, 0);
      drain(20);
      chk("mrst_rx_size", rxq.size(), 2);
      if (rxq.size() == 2) begin
         chk("mrst_rx0", {rxq[0].d, 31'b0, rxq[0].l}, {32'hB0, 32'h0});
         chk("mrst_rx1", {rxq[1].d, 31'b0, rxq[1].l}, {32'hB1, 32'h1});
      end

      // Wrap-around: 20 three-beat packets with random output stalls.
      rxq.delete();
      tx.delete();
      for (int p = 0; p < 20; p++)
         for (int b = 0; b < 3; b++) tx.push_back('{d: 32'h100 + p * 4 + b, l: b == 2});
      idx = 0;
      cyc = 0;
      while ((idx < 60 || mq.size() > 0) && cyc < 2000) begin
         sv = (idx < 60);
         sd = sv ? tx[idx].d : 32'h0;
         sl = sv ? tx[idx].l : 1'b0;
         mr = 1'($urandom_range(0, 1));
         cycle(0, sv, sd, sl, mr);
         if (sv && o_tready) idx++;
         cyc++;
      end
      chk("wrap_budget", cyc < 2000, 1);
`ifndef AXIS_PKT_FIFO_DROP_EN
      chk("wrap_rx_size", rxq.size(), 60);
      for (int i = 0; i < 60 && i < rxq.size(); i++) begin
         chk("wrap_rx_data", rxq[i].d, tx[i].d);
         chk("wrap_rx_last", rxq[i].l, tx[i].l);
      end
`endif

      // Random packet lengths, random valid/ready.
      len = 0;
      pos = 0;
      for (int c = 0; c < 600 || pos != 0; c++) begin
         if (c > 800) break;
         if (pos == 0) len = $urandom_range(1, 12);
         sv = (pos != 0) || ($urandom_range(0, 3) != 0);
         mr = ($urandom_range(0, 3) != 0);
         sd = $urandom;
         cycle(0, sv, sd, pos == len - 1, mr);
         if (sv && o_tready) pos = (pos == len - 1) ? 0 : pos + 1;
      end
      drain(60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
